// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Multicycle processor control unit. Sequences each instruction through
//   FETCH / DECODE / EXECUTE / MEM / WRITEBACK, decodes the opcode from the
//   instruction register and drives every datapath control strobe.
//   Supports R-type, LW, SW, BEQ, J and ADDI, memory wait states through
//   mem_ready, a sticky illegal-opcode trap and a retired-instruction counter.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   opCode       in   opcode field of the instruction register
//   mem_ready    in   memory completes its access this cycle
//   PCWrite .. RegDst        out  1-bit datapath strobes
//   ALUOp, ALUSrcB, PCSource out  2-bit datapath selects
//   state        out  current state encoding (debug)
//   illegal_op   out  sticky flag: an unknown opcode was decoded
//   instr_count  out  retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int                     OPCODE_W    = 6,
  parameter int                     CNT_W       = 32,
  parameter bit                     MEM_WAIT_EN = 1'b1,
  parameter logic [OPCODE_W-1:0]    OP_RTYPE    = OPCODE_W'(0),
  parameter logic [OPCODE_W-1:0]    OP_LW       = OPCODE_W'(35),
  parameter logic [OPCODE_W-1:0]    OP_SW       = OPCODE_W'(43),
  parameter logic [OPCODE_W-1:0]    OP_BEQ      = OPCODE_W'(4),
  parameter logic [OPCODE_W-1:0]    OP_J        = OPCODE_W'(2),
  parameter logic [OPCODE_W-1:0]    OP_ADDI     = OPCODE_W'(8)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                IRWrite,
  output logic                ALUSrcA,
  output logic                RegWrite,
  output logic                RegDst,
  output logic [1:0]          ALUOp,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic [3:0]          state,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_instr_count;
  logic             r_illegal_op;
  logic             w_rdy;

  // With wait states disabled the memory is assumed to always complete.
  assign w_rdy = mem_ready | ~MEM_WAIT_EN;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_instr_count <= '0;
      r_illegal_op  <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:  if (w_rdy) r_state <= S_DECODE;
        S_DECODE: begin
          if (opCode == OP_LW || opCode == OP_SW) r_state <= S_MEMADR;
          else if (opCode == OP_RTYPE)            r_state <= S_EXEC;
          else if (opCode == OP_BEQ)              r_state <= S_BRANCH;
          else if (opCode == OP_J)                r_state <= S_JUMP;
          else if (opCode == OP_ADDI)             r_state <= S_ADDIEX;
          else begin
            r_state      <= S_TRAP;
            r_illegal_op <= 1'b1;
          end
        end
        // IR is still stable here, so opCode is re-read instead of copied.
        S_MEMADR: r_state <= (opCode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (w_rdy) r_state <= S_MEMWB;
        S_MEMWR: begin
          if (w_rdy) begin
            r_state       <= S_FETCH;
            r_instr_count <= r_instr_count + 1'b1;
          end
        end
        S_EXEC:   r_state <= S_RWB;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
          r_state       <= S_FETCH;
          r_instr_count <= r_instr_count + 1'b1;
        end
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Moore outputs decoded from the current state. FETCH qualifies the PC and
  // IR writes with rdy so a stalled fetch increments the PC only once.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = w_rdy;
        PCWrite = w_rdy;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
    // Architectural writes are suppressed for the whole reset cycle, even
    // though the state register only returns to FETCH on the next edge.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
    end
  end

  assign state       = r_state;
  assign illegal_op  = r_illegal_op;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//   Directed bench for multicycle_ctrl_fsm. Instance dut uses the default
//   parameters; instance dut_b uses CNT_W=4 and MEM_WAIT_EN=0 for the
//   counter-wrap and no-wait cases. Strobes are compared as one packed word:
//   {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,
//    RegWrite,RegDst,ALUOp[1:0],ALUSrcB[1:0],PCSource[1:0]}
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

  localparam logic [5:0] OP_R = 6'd0, OP_LW = 6'd35, OP_SW = 6'd43;
  localparam logic [5:0] OP_BEQ = 6'd4, OP_J = 6'd2, OP_ADDI = 6'd8;

  // Hand-encoded expected strobe words per state.
  localparam logic [15:0] E_FETCH_RDY  = 16'h9204;
  localparam logic [15:0] E_FETCH_WAIT = 16'h1004;
  localparam logic [15:0] E_DECODE     = 16'h000C;
  localparam logic [15:0] E_MEMADR     = 16'h0108;
  localparam logic [15:0] E_MEMRD      = 16'h3000;
  localparam logic [15:0] E_MEMWB      = 16'h0480;
  localparam logic [15:0] E_MEMWR      = 16'h2800;
  localparam logic [15:0] E_MEMWR_RST  = 16'h2000;
  localparam logic [15:0] E_EXEC       = 16'h0120;
  localparam logic [15:0] E_RWB        = 16'h00C0;
  localparam logic [15:0] E_BRANCH     = 16'h4111;
  localparam logic [15:0] E_JUMP       = 16'h8002;
  localparam logic [15:0] E_ADDIEX     = 16'h0108;
  localparam logic [15:0] E_ADDIWB     = 16'h0080;
  localparam logic [15:0] E_NONE       = 16'h0000;

  logic        clk;
  logic        reset, mem_ready;
  logic [5:0]  opCode;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic        IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0]  ALUOp, ALUSrcB, PCSource;
  logic [3:0]  state;
  logic        illegal_op;
  logic [31:0] instr_count;

  logic        reset_b, mem_ready_b;
  logic [5:0]  opCode_b;
  logic        PCWrite_b, PCWriteCond_b, IorD_b, MemRead_b, MemWrite_b, MemtoReg_b;
  logic        IRWrite_b, ALUSrcA_b, RegWrite_b, RegDst_b;
  logic [1:0]  ALUOp_b, ALUSrcB_b, PCSource_b;
  logic [3:0]  state_b;
  logic        illegal_op_b;
  logic [3:0]  instr_count_b;

  logic [15:0] strb, strb_b;
  assign strb   = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource};
  assign strb_b = {PCWrite_b, PCWriteCond_b, IorD_b, MemRead_b, MemWrite_b, MemtoReg_b,
                   IRWrite_b, ALUSrcA_b, RegWrite_b, RegDst_b, ALUOp_b, ALUSrcB_b,
                   PCSource_b};

  multicycle_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opCode(opCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .state(state), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  multicycle_ctrl_fsm #(.CNT_W(4), .MEM_WAIT_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset_b), .opCode(opCode_b), .mem_ready(mem_ready_b),
    .PCWrite(PCWrite_b), .PCWriteCond(PCWriteCond_b), .IorD(IorD_b),
    .MemRead(MemRead_b), .MemWrite(MemWrite_b), .MemtoReg(MemtoReg_b),
    .IRWrite(IRWrite_b), .ALUSrcA(ALUSrcA_b), .RegWrite(RegWrite_b),
    .RegDst(RegDst_b), .ALUOp(ALUOp_b), .ALUSrcB(ALUSrcB_b), .PCSource(PCSource_b),
    .state(state_b), .illegal_op(illegal_op_b), .instr_count(instr_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Advance to 2 time units after the next rising edge; inputs change there.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Inputs are already set for this cycle: let them settle, check, advance.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] s);
    #1;
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".strb"},  32'(strb),  32'(s));
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int pc_pulses;
  int mw_cycles;
  logic [3:0] lw_states [5];

  initial begin
    reset = 1'b1; mem_ready = 1'b1; opCode = OP_LW;
    reset_b = 1'b1; mem_ready_b = 1'b0; opCode_b = OP_ADDI;
    step();

    // Reset state: PC/IR writes gated off while reset is still high.
    #1;
    check("rst.state", 32'(state), 32'd0);
    check("rst.count", instr_count, 32'd0);
    check("rst.illegal", 32'(illegal_op), 32'd0);
    check("rst.strb_gated", 32'(strb), 32'(E_FETCH_WAIT));

    // T1: LW, no waits.
    reset = 1'b0;
    cyc("t1.fetch", 4'd0, E_FETCH_RDY);
    cyc("t1.decode", 4'd1, E_DECODE);
    cyc("t1.memadr", 4'd2, E_MEMADR);
    cyc("t1.memrd", 4'd3, E_MEMRD);
    cyc("t1.memwb", 4'd4, E_MEMWB);
    #1;
    check("t1.end_state", 32'(state), 32'd0);
    check("t1.count", instr_count, 32'd1);

    // T2: R-type, BEQ, J from a fresh reset.
    do_reset();
    opCode = OP_R;
    cyc("t2.r.fetch", 4'd0, E_FETCH_RDY);
    cyc("t2.r.decode", 4'd1, E_DECODE);
    cyc("t2.r.exec", 4'd6, E_EXEC);
    cyc("t2.r.rwb", 4'd7, E_RWB);
    opCode = OP_BEQ;
    cyc("t2.beq.fetch", 4'd0, E_FETCH_RDY);
    cyc("t2.beq.decode", 4'd1, E_DECODE);
    cyc("t2.beq.branch", 4'd8, E_BRANCH);
    opCode = OP_J;
    cyc("t2.j.fetch", 4'd0, E_FETCH_RDY);
    cyc("t2.j.decode", 4'd1, E_DECODE);
    cyc("t2.j.jump", 4'd9, E_JUMP);
    #1;
    check("t2.count", instr_count, 32'd3);

    // T3: SW with 3 fetch waits and 2 MEMWR waits -> 9 cycles.
    opCode = OP_SW;
    pc_pulses = 0;
    mw_cycles = 0;
    for (int i = 0; i < 9; i++) begin
      mem_ready = !((i < 3) || (i == 6) || (i == 7));
      #1;
      if (PCWrite) pc_pulses++;
      if (MemWrite) mw_cycles++;
      step();
    end
    #1;
    check("t3.pc_pulses", 32'(pc_pulses), 32'd1);
    check("t3.memwrite_cycles", 32'(mw_cycles), 32'd3);
    check("t3.end_state", 32'(state), 32'd0);
    check("t3.count", instr_count, 32'd4);
    // Replay a single stalled MEMWR and FETCH cycle for the exact strobe word.
    mem_ready = 1'b0;
    cyc("t3.fetch_wait", 4'd0, E_FETCH_WAIT);
    mem_ready = 1'b1;
    cyc("t3.fetch", 4'd0, E_FETCH_RDY);
    cyc("t3.decode", 4'd1, E_DECODE);
    cyc("t3.memadr", 4'd2, E_MEMADR);
    mem_ready = 1'b0;
    cyc("t3.memwr_wait", 4'd5, E_MEMWR);
    mem_ready = 1'b1;
    cyc("t3.memwr", 4'd5, E_MEMWR);
    #1;
    check("t3.count2", instr_count, 32'd5);

    // T4: illegal opcode traps and stays trapped until reset.
    opCode = 6'h3F;
    cyc("t4.fetch", 4'd0, E_FETCH_RDY);
    cyc("t4.decode", 4'd1, E_DECODE);
    for (int i = 0; i < 20; i++) begin
      opCode = (i % 2 == 0) ? OP_LW : 6'h3F;
      #1;
      check("t4.trap_state", 32'(state), 32'd12);
      check("t4.trap_strb", 32'(strb), 32'(E_NONE));
      check("t4.illegal", 32'(illegal_op), 32'd1);
      step();
    end
    check("t4.count_held", instr_count, 32'd5);
    reset = 1'b1;
    #1;
    check("t4.rst_cycle_state", 32'(state), 32'd12);
    step();
    reset = 1'b0;
    #1;
    check("t4.after_rst_state", 32'(state), 32'd0);
    check("t4.after_rst_illegal", 32'(illegal_op), 32'd0);
    check("t4.after_rst_count", instr_count, 32'd0);

    // T5: reset while MEMWR is waiting.
    opCode = OP_SW; mem_ready = 1'b1;
    cyc("t5.fetch", 4'd0, E_FETCH_RDY);
    cyc("t5.decode", 4'd1, E_DECODE);
    cyc("t5.memadr", 4'd2, E_MEMADR);
    mem_ready = 1'b0;
    cyc("t5.memwr_wait", 4'd5, E_MEMWR);
    reset = 1'b1;
    cyc("t5.memwr_rst", 4'd5, E_MEMWR_RST);
    reset = 1'b0; mem_ready = 1'b1;
    cyc("t5.fetch_after", 4'd0, E_FETCH_RDY);

    // T6: CNT_W=4 wrap over 16 ADDIs, no wait states even with mem_ready=0.
    reset_b = 1'b0;
    opCode_b = OP_ADDI;
    #1;
    check("t6.addi.fetch_strb", 32'(strb_b), 32'(E_FETCH_RDY));
    step();
    #1;
    check("t6.addi.decode", 32'(state_b), 32'd1);
    step();
    #1;
    check("t6.addi.ex", 32'(state_b), 32'd10);
    check("t6.addi.ex_strb", 32'(strb_b), 32'(E_ADDIEX));
    step();
    #1;
    check("t6.addi.wb", 32'(state_b), 32'd11);
    check("t6.addi.wb_strb", 32'(strb_b), 32'(E_ADDIWB));
    step();
    for (int i = 1; i < 16; i++) begin
      #1;
      check("t6.count", 32'(instr_count_b), 32'(i));
      repeat (4) step();
    end
    #1;
    check("t6.wrap", 32'(instr_count_b), 32'd0);
    check("t6.wrap_state", 32'(state_b), 32'd0);

    opCode_b = OP_LW;
    lw_states[0] = 4'd0; lw_states[1] = 4'd1; lw_states[2] = 4'd2;
    lw_states[3] = 4'd3; lw_states[4] = 4'd4;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t6.lw_state", 32'(state_b), 32'(lw_states[i]));
      step();
    end
    #1;
    check("t6.lw_done_state", 32'(state_b), 32'd0);
    check("t6.lw_count", 32'(instr_count_b), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
